id_ex_stage: RTL

Decode/operand-capture stage and ID/EX pipeline register directly upstream of the ALU. It takes the fetched instruction from IF/ID, reads the register file, resolves data hazards by forwarding or by a one-cycle load-use stall, and registers `instruction`/`regA`/`regB` plus control bits for the EX stage. It also handles branch flush and keeps a saturating bubble counter.

---
 rtl/id_ex_stage.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// Decode / operand-capture stage with the ID/EX pipeline register feeding the ALU.
// Resolves RAW hazards by forwarding from EX/MEM/WB or by a one-cycle load-use bubble.
module id_ex_stage #(
  parameter int BUBBLE_CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [31:0]             id_instr,
  output logic [4:0]              rf_rs_addr,
  output logic [4:0]              rf_rt_addr,
  input  logic [31:0]             rf_rs_data,
  input  logic [31:0]             rf_rt_data,
  input  logic [31:0]             ex_alu_result,
  input  logic                    mem_reg_write,
  input  logic [4:0]              mem_dest,
  input  logic [31:0]             mem_data,
  input  logic                    wb_reg_write,
  input  logic [4:0]              wb_dest,
  input  logic [31:0]             wb_data,
  input  logic                    flush,
  output logic                    stall,
  output logic                    ex_valid,
  output logic [31:0]             ex_instruction,
  output logic [31:0]             ex_regA,
  output logic [31:0]             ex_regB,
  output logic [4:0]              ex_dest,
  output logic                    ex_reg_write,
  output logic                    ex_mem_read,
  output logic                    ex_mem_write,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  logic                    ex_valid_reg;
  logic [31:0]             ex_instruction_reg;
  logic [31:0]             ex_regA_reg;
  logic [31:0]             ex_regB_reg;
  logic [4:0]              ex_dest_reg;
  logic                    ex_reg_write_reg;
  logic                    ex_mem_read_reg;
  logic                    ex_mem_write_reg;
  logic [BUBBLE_CNT_W-1:0] bubble_cnt_reg;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign opcode = id_instr[31:26];
  assign rs     = id_instr[25:21];
  assign rt     = id_instr[20:16];
  assign rd     = id_instr[15:11];
  assign funct  = id_instr[5:0];

  assign rf_rs_addr = rs;
  assign rf_rt_addr = rt;

  logic [4:0] dec_dest;
  logic       dec_write;
  logic       dec_mem_read;
  logic       dec_mem_write;
  logic       use_rs;
  logic       use_rt;
  logic       shift_fixed;
  logic       shift_var;

  always_comb begin
    dec_dest      = 5'd0;
    dec_write     = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    use_rs        = 1'b1;
    use_rt        = 1'b0;
    shift_fixed   = 1'b0;
    shift_var     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_dest  = rd;
        dec_write = 1'b1;
        use_rt    = 1'b1;
        case (funct)
          6'b000000, 6'b000010, 6'b000011: begin
            shift_fixed = 1'b1;
            use_rs      = 1'b0;
          end
          6'b000100, 6'b000110, 6'b000111: shift_var = 1'b1;
          default: ;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
        dec_dest  = rt;
        dec_write = 1'b1;
      end
      OP_LW: begin
        dec_dest     = rt;
        dec_write    = 1'b1;
        dec_mem_read = 1'b1;
      end
      OP_SW: begin
        dec_mem_write = 1'b1;
        use_rt        = 1'b1;
      end
      OP_BEQ, OP_BNE: use_rt = 1'b1;
      default: ;
    endcase
    // Writes to $0 are architecturally discarded, so never advertise them.
    if (dec_dest == 5'd0) begin
      dec_write = 1'b0;
    end
  end

  // A load in EX has no data yet; it is only reachable from MEM next cycle.
  logic ex_fwd_ok;
  assign ex_fwd_ok = ex_valid_reg && ex_reg_write_reg && !ex_mem_read_reg;

  logic [1:0][4:0]  src_addr;
  logic [1:0][31:0] src_rf;
  logic [1:0]       src_use;

  assign src_addr = {rt, rs};
  assign src_rf   = {rf_rt_data, rf_rs_data};
  assign src_use  = {use_rt, use_rs};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [31:0] val;
      logic        hazard;

      always_comb begin
        val = src_rf[gi];
        if (src_addr[gi] == 5'd0) begin
          val = 32'd0;
        end else if (ex_fwd_ok && ex_dest_reg == src_addr[gi]) begin
          val = ex_alu_result;
        end else if (mem_reg_write && mem_dest == src_addr[gi]) begin
          val = mem_data;
        end else if (wb_reg_write && wb_dest == src_addr[gi]) begin
          val = wb_data;
        end
      end

      assign hazard = src_use[gi] && (src_addr[gi] == ex_dest_reg);
    end
  endgenerate

  logic [31:0] opnd_a;
  logic [31:0] opnd_b;

  assign opnd_a = (shift_fixed || shift_var) ? g_fwd[1].val : g_fwd[0].val;
  assign opnd_b = shift_fixed ? 32'd0 : (shift_var ? g_fwd[0].val : g_fwd[1].val);

  assign stall = id_valid && ex_valid_reg && ex_mem_read_reg && (ex_dest_reg != 5'd0) &&
                 (g_fwd[0].hazard || g_fwd[1].hazard) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg       <= 1'b0;
      ex_instruction_reg <= 32'd0;
      ex_regA_reg        <= 32'd0;
      ex_regB_reg        <= 32'd0;
      ex_dest_reg        <= 5'd0;
      ex_reg_write_reg   <= 1'b0;
      ex_mem_read_reg    <= 1'b0;
      ex_mem_write_reg   <= 1'b0;
      bubble_cnt_reg     <= '0;
    end else if (flush || stall || !id_valid) begin
      ex_valid_reg       <= 1'b0;
      ex_instruction_reg <= 32'd0;
      ex_regA_reg        <= 32'd0;
      ex_regB_reg        <= 32'd0;
      ex_dest_reg        <= 5'd0;
      ex_reg_write_reg   <= 1'b0;
      ex_mem_read_reg    <= 1'b0;
      ex_mem_write_reg   <= 1'b0;
      // Only load-use bubbles are counted; flush already has priority over stall.
      if (stall && bubble_cnt_reg != '1) begin
        bubble_cnt_reg <= bubble_cnt_reg + 1'b1;
      end
    end else begin
      ex_valid_reg       <= 1'b1;
      ex_instruction_reg <= id_instr;
      ex_regA_reg        <= opnd_a;
      ex_regB_reg        <= opnd_b;
      ex_dest_reg        <= dec_dest;
      ex_reg_write_reg   <= dec_write;
      ex_mem_read_reg    <= dec_mem_read;
      ex_mem_write_reg   <= dec_mem_write;
    end
  end

  assign ex_valid       = ex_valid_reg;
  assign ex_instruction = ex_instruction_reg;
  assign ex_regA        = ex_regA_reg;
  assign ex_regB        = ex_regB_reg;
  assign ex_dest        = ex_dest_reg;
  assign ex_reg_write   = ex_reg_write_reg;
  assign ex_mem_read    = ex_mem_read_reg;
  assign ex_mem_write   = ex_mem_write_reg;
  assign bubble_cnt     = bubble_cnt_reg;

endmodule
